// File: rtl/gated_clock_pkg.sv
// Shared constants for the gated clock block.
// Synchronizer depth and the only supported idle level.
package gated_clock_pkg;

    localparam int SYNC_STAGES    = 2;
    localparam int SUPPORTED_IDLE = 0;

endpackage

// File: rtl/clock_gate_cell.sv
// Latch-plus-AND clock gate, kept separate so a technology ICG can replace it.
// The latch is transparent while clock is low, so output pulses are never partial.
module clock_gate_cell (
    input  logic clock,
    input  logic reset,
    input  logic gate_request,
    output logic clock_output,
    output logic latch_q
);

    always_latch begin
        if (!reset)
            latch_q <= 1'b0;
        else if (!clock)
            latch_q <= gate_request;
    end

    assign clock_output = clock & latch_q;

endmodule

// File: rtl/gated_clock.sv
// Gated clock with falling-edge reset release, scan bypass and a
// saturating count of pulses emitted since the gate last opened.
module gated_clock #(
    parameter int COUNT_W    = 16,
    parameter int IDLE_LEVEL = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               test_enable,
    output logic               clock_output,
    output logic               gate_open,
    output logic [COUNT_W-1:0] pulse_count
);

    import gated_clock_pkg::*;

    if (IDLE_LEVEL != SUPPORTED_IDLE) begin : g_bad_idle
        $error("gated_clock: only IDLE_LEVEL = 0 is supported");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   rst_sync;
    logic                   gate_request;
    logic                   latch_q;
    logic                   was_open;
    logic [COUNT_W-1:0]     count;

    // Assert asynchronously, release on the falling edge.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset)
            sync <= '0;
        else
            sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_sync     = sync[SYNC_STAGES-1];
    assign gate_request = enable | test_enable;

    clock_gate_cell u_cell (
        .clock        (clock),
        .reset        (rst_sync),
        .gate_request (gate_request),
        .clock_output (clock_output),
        .latch_q      (latch_q)
    );

    // was_open is the latch value seen at the previous rising edge.
    always_ff @(posedge clock or negedge rst_sync) begin
        if (!rst_sync) begin
            count    <= '0;
            was_open <= 1'b0;
        end else begin
            was_open <= latch_q;
            if (latch_q) begin
                if (!was_open)
                    count <= COUNT_W'(1);
                else if (count != '1)
                    count <= count + COUNT_W'(1);
            end
        end
    end

    // A freshly opened gate reads zero until its first pulse lands.
    assign pulse_count = (latch_q && !was_open) ? '0 : count;
    assign gate_open   = latch_q;

endmodule

// File: tb/tb_gated_clock.sv
// Scoreboard bench for gated_clock: bursts, bypass, async reset,
// mid-phase enable changes and counter saturation.
module tb_gated_clock;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        test_enable;
    logic        clock_output;
    logic        gate_open;
    logic [15:0] pulse_count;

    logic        en4;
    logic        clock_output4;
    logic        gate_open4;
    logic [3:0]  pulse_count4;

    gated_clock #(.COUNT_W(16), .IDLE_LEVEL(0)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .test_enable  (test_enable),
        .clock_output (clock_output),
        .gate_open    (gate_open),
        .pulse_count  (pulse_count)
    );

    gated_clock #(.COUNT_W(4), .IDLE_LEVEL(0)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .enable       (en4),
        .test_enable  (1'b0),
        .clock_output (clock_output4),
        .gate_open    (gate_open4),
        .pulse_count  (pulse_count4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int    exp_q[$];
    string tag_q[$];

    task automatic push(input string tag, input int val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic pop(input longint got);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            chk(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    int  pulses  = 0;
    int  pulses4 = 0;
    int  bad_w   = 0;
    time t_rise  = 0;
    time t_rise4 = 0;

    always @(posedge clock_output) begin
        pulses++;
        t_rise = $time;
    end

    always @(negedge clock_output) begin
        if (reset && ($time - t_rise != 5))
            bad_w++;
    end

    always @(posedge clock_output4) begin
        pulses4++;
        t_rise4 = $time;
    end

    always @(negedge clock_output4) begin
        if (reset && ($time - t_rise4 != 5))
            bad_w++;
    end

    task automatic falls(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic release_reset();
        falls(1);
        reset = 1'b1;
        falls(3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        test_enable = 1'b0;
        en4         = 1'b0;
        #1;
        chk("reset_clock_output", clock_output, 0);
        chk("reset_gate_open", gate_open, 0);
        chk("reset_pulse_count", pulse_count, 0);
        falls(2);
        release_reset();
        chk("idle_gate_open", gate_open, 0);

        // Eight-pulse burst.
        base   = pulses;
        enable = 1'b1;
        push("burst_pulses", 8);
        push("burst_count", 8);
        push("burst_gate_closed", 0);
        falls(4);
        chk("burst_mid_count", pulse_count, 4);
        chk("burst_mid_open", gate_open, 1);
        falls(4);
        enable = 1'b0;
        falls(2);
        pop(pulses - base);
        pop(pulse_count);
        pop(gate_open);

        // Enable pulse entirely within a high phase.
        base = pulses;
        push("high_toggle_pulses", 0);
        push("high_toggle_count", 8);
        @(posedge clock);
        #1 enable = 1'b1;
        #2 enable = 1'b0;
        falls(3);
        pop(pulses - base);
        pop(pulse_count);

        // Enable pulse entirely within a low phase.
        base = pulses;
        push("low_toggle_pulses", 0);
        @(negedge clock);
        #1 enable = 1'b1;
        #1 enable = 1'b0;
        falls(3);
        pop(pulses - base);

        // Bypass with enable low.
        base        = pulses;
        test_enable = 1'b1;
        push("bypass_pulses", 5);
        push("bypass_count", 5);
        falls(5);
        test_enable = 1'b0;
        @(posedge clock);
        #1;
        chk("bypass_off_output", clock_output, 0);
        falls(2);
        pop(pulses - base);
        pop(pulse_count);

        // Re-open: count restarts rather than accumulating.
        base   = pulses;
        enable = 1'b1;
        #1;
        chk("reopen_cleared", pulse_count, 0);
        chk("reopen_gate_open", gate_open, 1);
        push("reopen_pulses", 3);
        push("reopen_count", 3);
        falls(3);
        enable = 1'b0;
        falls(2);
        pop(pulses - base);
        pop(pulse_count);

        // Async reset mid-high phase during a burst.
        falls(1);
        enable = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("areset_output", clock_output, 0);
        chk("areset_gate_open", gate_open, 0);
        chk("areset_count", pulse_count, 0);
        base = pulses;
        push("areset_no_pulses", 0);
        falls(3);
        pop(pulses - base);
        base  = pulses;
        reset = 1'b1;
        push("resume_pulses", 2);
        push("resume_count", 2);
        falls(4);
        enable = 1'b0;
        falls(2);
        pop(pulses - base);
        pop(pulse_count);

        // Saturation on the narrow counter.
        base = pulses4;
        en4  = 1'b1;
        push("sat_count_16", 15);
        push("sat_pulses", 20);
        push("sat_count_hold", 15);
        falls(16);
        pop(pulse_count4);
        falls(4);
        en4 = 1'b0;
        falls(2);
        pop(pulses4 - base);
        pop(pulse_count4);

        chk("full_width_pulses", bad_w, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
